lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial PRBS checker and synchronizer for the 8-bit LFSR test generator. The generator's state update is `state <= {s4^s3^s2^s0, state[7:1]}`, and its output stream is `state[0]` taken each step. This block receives that bit stream, self-synchronizes to it, then flags and counts bit errors. It sits at the receive end of link and shift-register loopback tests and reports lock status and error statistics to the test harness.

## Interface
- `LOCK_CNT`, default 16: consecutive correct predictions in HUNT required to declare lock.
- `UNLOCK_CNT`, default 4: consecutive mispredictions in LOCKED that force a return to HUNT.
- `CNT_W`, default 16: width of the error and bit counters.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `din_valid`  in  1: `din` carries one stream bit this cycle.
- `din`  in  1: received stream bit.
- `clr_cnt`  in  1: synchronous clear of `err_cnt` and `bit_cnt`.
- `locked`  out  1: checker is synchronized (state LOCKED).
- `err_pulse`  out  1: one-cycle strobe per mismatched bit while LOCKED.
- `err_cnt`  out  CNT_W: saturating count of mismatched bits while LOCKED.
- `bit_cnt`  out  CNT_W: saturating count of bits checked while LOCKED.

## Operation
- **Window.** `w[7:0]`: `w[0]` is the oldest bit, `w[7]` the newest, so `w` equals the generator state. The predicted next bit is `p = w[4]^w[3]^w[2]^w[0]`. Shift rule: `w <= {new, w[7:1]}`. Only valid cycles advance anything; cycles with `din_valid=0` change nothing except `clr_cnt` and `err_pulse`, which is forced to 0.
- **FILL** (state after reset):
  - Shift `din` into `w`. A 4-bit fill counter counts to 8; on the 8th valid bit, go to HUNT.
- **HUNT:**
  - Compare `din` with `p`, then shift `din` into `w`.
  - `match_cnt` increments on a match when `w != 0`. It clears on a mismatch or when `w == 0`, which is the illegal lockup state.
  - When `match_cnt` reaches `LOCK_CNT`, go to LOCKED and clear `miss_cnt`.
- **LOCKED:**
  - Compare `din` with `p`. `bit_cnt` increments, saturating at all-ones.
  - On a mismatch: `err_pulse=1`, `err_cnt` increments (saturating), and `miss_cnt` increments.
  - On a match: `miss_cnt` clears.
  - When `miss_cnt` reaches `UNLOCK_CNT`, go to HUNT with `match_cnt=0`. The window is retained, so no refill is needed.
  - The window shift source is set by the Configuration macro.
- **Counters.** `err_cnt` and `bit_cnt` are not cleared by unlock. `clr_cnt` clears both and takes priority over a same-cycle increment; that event is dropped.
- **Reset.** `rst` has priority over everything, including mid-stream and while locked. It returns the block to FILL with all state cleared.

## Timing
- Reset values: `locked=0`, `err_pulse=0`, `err_cnt=0`, `bit_cnt=0`, `w=0`, fill/match/miss counters 0.
- All outputs are registered, with 1-cycle latency: the bit sampled at edge N is reflected in `locked`, `err_pulse` and the counters after edge N.
- `locked` rises at the edge that samples the (8+`LOCK_CNT`)th valid bit of a clean stream.
- `locked` falls at the edge that samples the `UNLOCK_CNT`th consecutive bad bit. That bit still produces `err_pulse` and is counted.
- `din_valid` may toggle arbitrarily. There is no back-pressure.

## Configuration
- `LFSR_CHECKER_FLYWHEEL_EN`:
  - **Defined:** in LOCKED the window shifts in the predicted bit `p`, so the local LFSR free-runs and a single channel bit error yields exactly one mismatch.
  - **Undefined:** the window always shifts in `din` (self-synchronous). A single bit error at bit k yields mismatches at k, k+4, k+5, k+6 and k+8, i.e. 5 errors. The longest consecutive run is 3, so lock holds with `UNLOCK_CNT=4`.
  - FILL and HUNT behave identically in both builds.

## Test plan
- **Reset state:** assert `rst` for 2 cycles with arbitrary `din` -> `locked=0`, `err_pulse=0`, `err_cnt=0`, `bit_cnt=0`.
- **Clean lock:** feed the generator stream from seed 0x01 (first bits 1,0,0,0,0,0,0,0,1,...) with `din_valid=1` -> `locked` rises after the 24th bit. Over 1000 further bits, `err_cnt` stays 0 and `bit_cnt=1000`.
- **Single error while locked:** invert one bit -> with the macro, one `err_pulse` and `err_cnt=1`. Without it, 5 pulses at offsets 0, 4, 5, 6, 8, `err_cnt=5`, and `locked` stays 1.
- **Gapped valid:** clean stream with `din_valid` low on every other cycle -> lock after 24 valid bits (about 48 cycles). No errors; idle cycles are not counted.
- **Loss of lock:** while locked, invert 4 consecutive bits -> `err_cnt=4` and `locked` falls on the 4th. A subsequent clean stream relocks after 16 matches (within 24 bits) without a refill.
- **Clear and reset:** assert `clr_cnt` in the same cycle as an error -> `err_cnt=0`. Assert `rst` mid-lock -> outputs return to their reset values, and relock takes 24 bits again.

Source files
------------

// File: rtl/lfsr_checker.sv
// Serial PRBS checker for the 8-bit LFSR generator: self-synchronizes, then flags and counts bit errors.
// Optional build macro: LFSR_CHECKER_FLYWHEEL_EN (free-running local LFSR while locked).
module lfsr_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    logic [1:0]    state;
    logic [7:0]    w;
    logic [3:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [UW-1:0] miss_cnt;
    logic          p;
    logic          mis;
    logic          shift_bit;

    // w mirrors the generator state, so p is the generator's next output bit
    assign p      = w[4] ^ w[3] ^ w[2] ^ w[0];
    assign mis    = din ^ p;
    assign locked = (state == S_LOCKED);

`ifdef LFSR_CHECKER_FLYWHEEL_EN
    assign shift_bit = (state == S_LOCKED) ? p : din;
`else
    assign shift_bit = din;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FILL;
            w         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                w <= {shift_bit, w[7:1]};
                case (state)
                    S_FILL: begin
                        if (fill_cnt == 4'd7) begin
                            state    <= S_HUNT;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    S_HUNT: begin
                        // an all-zero window is the LFSR lockup state and never counts as a match
                        if (!mis && (w != 8'd0)) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state    <= S_LOCKED;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
                        if (mis) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                            if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
                                state     <= S_HUNT;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= S_FILL;
                endcase
            end
            // clear wins over a same-cycle increment
            if (clr_cnt) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: constant vector table, directed corner sequences and random traffic vs a queue-based model.
module tb_lfsr_checker;

    localparam int LOCK   = 16;
    localparam int UNLOCK = 4;
    localparam int CW     = 16;
    localparam int CW2    = 4;

    logic          clk = 1'b0;
    logic          rst, din_valid, din, clr_cnt;
    logic          locked, err_pulse, locked2, err_pulse2;
    logic [CW-1:0] err_cnt, bit_cnt;
    logic [CW2-1:0] err_cnt2, bit_cnt2;

    lfsr_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt));

    // narrow-counter copy so saturation is reachable
    lfsr_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .bit_cnt(bit_cnt2));

    always #5 clk = ~clk;

`ifdef LFSR_CHECKER_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: mode 0 fill, 1 hunt, 2 locked; hist[0] is the oldest received bit
    int  m_mode, m_match, m_miss, raw_err, raw_bit;
    bit  m_pulse;
    bit  hist[$];
    logic [7:0] g;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int raw, input int width);
        int mx;
        mx = (1 << width) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit d, input bit c);
        bit p, allz, nb;
        if (r) begin
            m_mode = 0; m_match = 0; m_miss = 0; raw_err = 0; raw_bit = 0; m_pulse = 0;
            hist.delete();
            return;
        end
        m_pulse = 0;
        if (v) begin
            if (m_mode == 0) begin
                hist.push_back(d);
                if (hist.size() == 8) m_mode = 1;
            end else begin
                p = hist[4] ^ hist[3] ^ hist[2] ^ hist[0];
                allz = 1;
                foreach (hist[i]) if (hist[i]) allz = 0;
                nb = d;
                if (m_mode == 1) begin
                    if (d == p && !allz) m_match++;
                    else m_match = 0;
                    if (m_match == LOCK) begin m_mode = 2; m_miss = 0; end
                end else begin
                    raw_bit++;
                    if (d != p) begin m_pulse = 1; raw_err++; m_miss++; end
                    else m_miss = 0;
                    if (FLY) nb = p;
                    if (m_miss == UNLOCK) begin m_mode = 1; m_match = 0; end
                end
                hist.push_back(nb);
                void'(hist.pop_front());
            end
        end
        if (c) begin raw_err = 0; raw_bit = 0; end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit c);
        rst = r; din_valid = v; din = d; clr_cnt = c;
        @(posedge clk);
        #1;
        model_step(r, v, d, c);
        check("locked", locked, (m_mode == 2));
        check("err_pulse", err_pulse, m_pulse);
        check("err_cnt", err_cnt, sat(raw_err, CW));
        check("bit_cnt", bit_cnt, sat(raw_bit, CW));
        check("locked_n", locked2, (m_mode == 2));
        check("err_cnt_sat", err_cnt2, sat(raw_err, CW2));
        check("bit_cnt_sat", bit_cnt2, sat(raw_bit, CW2));
    endtask

    task automatic gen_bit(output bit b);
        b = g[0];
        g = {g[4] ^ g[3] ^ g[2] ^ g[0], g[7:1]};
    endtask

    typedef struct {
        bit r, v, d, c;
        bit exp_locked, exp_pulse;
        int exp_err, exp_bit;
    } vec_t;

    initial begin
        vec_t tbl[6];
        bit   b;
        int   npulse, at;
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        model_step(1, 0, 0, 0);

        tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 1, 1, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            rst = tbl[i].r; din_valid = tbl[i].v; din = tbl[i].d; clr_cnt = tbl[i].c;
            @(posedge clk);
            #1;
            model_step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
            check("tbl_locked", locked, tbl[i].exp_locked);
            check("tbl_pulse", err_pulse, tbl[i].exp_pulse);
            check("tbl_err", err_cnt, tbl[i].exp_err);
            check("tbl_bit", bit_cnt, tbl[i].exp_bit);
        end

        // clean lock from seed 0x01
        g = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            gen_bit(b);
            step(0, 1, b, 0);
            if (i == 23) check("no_lock_23", locked, 0);
        end
        check("lock_at_24", locked, 1);
        for (int i = 0; i < 1000; i++) begin gen_bit(b); step(0, 1, b, 0); end
        check("clean_err", err_cnt, 0);
        check("clean_bits", bit_cnt, 1000);

        // single inverted bit while locked
        step(0, 0, 0, 1);
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            step(0, 1, b ^ (i == 2), 0);
            if (err_pulse) npulse++;
            if (!locked) check("single_err_keeps_lock", locked, 1);
        end
        check("single_err_pulses", npulse, FLY ? 1 : 5);
        check("single_err_cnt", err_cnt, FLY ? 1 : 5);

        // four consecutive bad bits drop lock, then relock without refill
        step(0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            gen_bit(b);
            step(0, 1, ~b, 0);
            if (i == 3) check("lock_held_3", locked, 1);
        end
        check("unlock_on_4th", locked, 0);
        check("unlock_err_cnt", err_cnt, 4);
        at = 0;
        for (int i = 1; i <= 30 && at == 0; i++) begin
            gen_bit(b);
            step(0, 1, b, 0);
            if (locked) at = i;
        end
        check("relock_within_24", (at >= 16 && at <= 24), 1);
        check("relock_err_cnt", err_cnt, 4);

        // clear in the same cycle as an error
        for (int i = 0; i < 4; i++) begin gen_bit(b); step(0, 1, b, 0); end
        gen_bit(b);
        step(0, 1, ~b, 1);
        check("clr_beats_err", err_cnt, 0);
        for (int i = 0; i < 10; i++) begin gen_bit(b); step(0, 1, b, 0); end

        // reset mid-lock, then relock takes 24 bits again
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err_cnt, 0);
        check("rst_bit", bit_cnt, 0);
        at = 0;
        for (int i = 1; i <= 30 && at == 0; i++) begin
            gen_bit(b);
            step(0, 1, b, 0);
            if (locked) at = i;
        end
        check("relock_after_rst", at, 24);

        // gapped valid from seed 0x01
        step(1, 0, 0, 0);
        g = 8'h01;
        at = 0;
        for (int i = 1; i <= 24; i++) begin
            gen_bit(b);
            step(0, 0, 1'($urandom), 0);
            step(0, 1, b, 0);
            if (locked && at == 0) at = i;
        end
        check("gapped_lock_at", at, 24);
        check("gapped_bits", bit_cnt, 0);

        // all-zero stream is the lockup state and must never lock
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
        check("zero_no_lock", locked, 0);

        // random traffic: gaps, sparse errors, clears, rare resets
        step(1, 0, 0, 0);
        g = 8'($urandom_range(1, 255));
        for (int i = 0; i < 3000; i++) begin
            bit v, e, c, r;
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 63) == 0);
            r = ($urandom_range(0, 499) == 0);
            if (v) begin gen_bit(b); step(r, 1, b ^ e, c); end
            else step(r, 0, 1'($urandom), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
